// File: rtl/decode_pipe_stage.sv
// Instruction decode stage: splits fields, decodes the immediate and reads two GPR operands.
// Results are registered into an ID/EX slot with a valid/ready handshake on both sides.
module decode_pipe_stage #(
  parameter int XLEN      = 32,
  parameter int GPR_COUNT = 32,
  parameter int GPR_BITS  = 5,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instruction,
  input  logic [2:0]          imm_type,
  input  logic                flush,
  input  logic                ex_load,
  input  logic [GPR_BITS-1:0] ex_rd,
  input  logic                wb_we,
  input  logic [GPR_BITS-1:0] wb_rd,
  input  logic [XLEN-1:0]     wb_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic                funct7_bit5,
  output logic [GPR_BITS-1:0] rs1,
  output logic [GPR_BITS-1:0] rs2,
  output logic [GPR_BITS-1:0] rd,
  output logic [XLEN-1:0]     imm,
  output logic [XLEN-1:0]     gpr1_value,
  output logic [XLEN-1:0]     gpr2_value
);

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_kind_e;

  logic [XLEN-1:0]     gpr [GPR_COUNT];
  logic [GPR_BITS-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [31:0]         imm32;
  logic [XLEN-1:0]     imm_ext;
  logic [XLEN-1:0]     rd1_value, rd2_value;
  logic                wb_write, hazard, free;

  assign dec_rs1  = instruction[15 +: GPR_BITS];
  assign dec_rs2  = instruction[20 +: GPR_BITS];
  assign dec_rd   = instruction[7 +: GPR_BITS];
  assign wb_write = wb_we && (wb_rd != '0);

  // Both source fields are compared regardless of format, so some stalls are spurious.
  assign hazard   = in_valid && ex_load && (ex_rd != '0) &&
                    ((dec_rs1 == ex_rd) || (dec_rs2 == ex_rd));
  assign free     = !out_valid || out_ready;
  assign in_ready = free && !hazard && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    imm32 = '0;
    case (imm_kind_e'(imm_type))
      IMM_I:   imm32 = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S:   imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B:   imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:   imm32 = {instruction[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  // Without bypass the array read sees the value from before this edge's write.
  always_comb begin
    rd1_value = (dec_rs1 == '0) ? '0 : gpr[dec_rs1];
    rd2_value = (dec_rs2 == '0) ? '0 : gpr[dec_rs2];
    if (BYPASS_WB && wb_write && (wb_rd == dec_rs1)) rd1_value = wb_result;
    if (BYPASS_WB && wb_write && (wb_rd == dec_rs2)) rd2_value = wb_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the regfile is cleared on reset because software may read GPRs before writing them.
      for (int i = 0; i < GPR_COUNT; i++) gpr[i] <= '0;
    end else if (wb_write) begin
      gpr[wb_rd] <= wb_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples values from before the edge.
      out_valid   <= 1'b0;
      opcode      <= '0;
      funct3      <= '0;
      funct7_bit5 <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      imm         <= '0;
      gpr1_value  <= '0;
      gpr2_value  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (free) begin
      if (hazard || !in_valid) begin
        out_valid <= 1'b0;
      end else begin
        out_valid   <= 1'b1;
        opcode      <= instruction[6:0];
        funct3      <= instruction[14:12];
        funct7_bit5 <= instruction[30];
        rs1         <= dec_rs1;
        rs2         <= dec_rs2;
        rd          <= dec_rd;
        imm         <= imm_ext;
        gpr1_value  <= rd1_value;
        gpr2_value  <= rd2_value;
      end
    end else if (BYPASS_WB && wb_write) begin
      // Held payload: keep operands current with writebacks that land while EX stalls.
      if (wb_rd == rs1) gpr1_value <= wb_result;
      if (wb_rd == rs2) gpr2_value <= wb_result;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the stage.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, ex_load, wb_we, out_valid, out_ready;
  logic [31:0] instruction, wb_result;
  logic [2:0]  imm_type;
  logic [4:0]  ex_rd, wb_rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_bit5;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, gpr1_value, gpr2_value;

  logic        d64_in_ready, d64_out_valid, d64_funct7_bit5;
  logic [6:0]  d64_opcode;
  logic [2:0]  d64_funct3;
  logic [4:0]  d64_rs1, d64_rs2, d64_rd;
  logic [63:0] d64_imm, d64_gpr1_value, d64_gpr2_value;

  always #5 clk = ~clk;

  decode_pipe_stage #(.XLEN(32), .GPR_COUNT(32), .GPR_BITS(5), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .imm_type(imm_type), .flush(flush),
    .ex_load(ex_load), .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_result(wb_result), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct3(funct3), .funct7_bit5(funct7_bit5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .gpr1_value(gpr1_value), .gpr2_value(gpr2_value)
  );

  decode_pipe_stage #(.XLEN(64), .GPR_COUNT(32), .GPR_BITS(5), .BYPASS_WB(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d64_in_ready),
    .instruction(instruction), .imm_type(imm_type), .flush(flush),
    .ex_load(ex_load), .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_result({32'h0, wb_result}), .out_valid(d64_out_valid), .out_ready(out_ready),
    .opcode(d64_opcode), .funct3(d64_funct3), .funct7_bit5(d64_funct7_bit5),
    .rs1(d64_rs1), .rs2(d64_rs2), .rd(d64_rd), .imm(d64_imm),
    .gpr1_value(d64_gpr1_value), .gpr2_value(d64_gpr2_value)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, g1, g2;
  } payload_t;

  payload_t    m_pay;
  bit          m_valid;
  logic [31:0] m_gpr [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate as signed arithmetic on the instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] t);
    int s, hi, r;
    s  = $signed(ins);
    hi = s >>> 31;
    case (t)
      3'd0:    r = s >>> 20;
      3'd1:    r = (s >>> 25) * 32 + int'(ins[11:7]);
      3'd2:    r = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      3'd3:    r = int'(ins & 32'hFFFF_F000);
      3'd4:    r = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                   int'(ins[30:21]) * 2;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_we && wb_rd == r) return wb_result;
    return m_gpr[r];
  endfunction

  function automatic bit ref_hazard();
    return in_valid && ex_load && ex_rd != 0 &&
           (instruction[19:15] == ex_rd || instruction[24:20] == ex_rd);
  endfunction

  function automatic bit ref_in_ready();
    return (!m_valid || out_ready) && !ref_hazard() && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_pay   = '{default: '0};
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
  endtask

  task automatic model_step();
    bit free;
    free = !m_valid || out_ready;
    if (flush) begin
      m_valid = 0;
    end else if (free && (ref_hazard() || !in_valid)) begin
      m_valid = 0;
    end else if (free) begin
      m_valid       = 1;
      m_pay.opcode  = instruction[6:0];
      m_pay.funct3  = instruction[14:12];
      m_pay.f7b5    = instruction[30];
      m_pay.rs1     = instruction[19:15];
      m_pay.rs2     = instruction[24:20];
      m_pay.rd      = instruction[11:7];
      m_pay.imm     = ref_imm(instruction, imm_type);
      m_pay.g1      = ref_operand(instruction[19:15]);
      m_pay.g2      = ref_operand(instruction[24:20]);
    end else if (wb_we && wb_rd != 0) begin
      if (wb_rd == m_pay.rs1) m_pay.g1 = wb_result;
      if (wb_rd == m_pay.rs2) m_pay.g2 = wb_result;
    end
    if (wb_we && wb_rd != 0) m_gpr[wb_rd] = wb_result;
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("opcode", opcode, m_pay.opcode);
      check("funct3", funct3, m_pay.funct3);
      check("funct7_bit5", funct7_bit5, m_pay.f7b5);
      check("rs1", rs1, m_pay.rs1);
      check("rs2", rs2, m_pay.rs2);
      check("rd", rd, m_pay.rd);
      check("imm", imm, m_pay.imm);
      check("gpr1_value", gpr1_value, m_pay.g1);
      check("gpr2_value", gpr2_value, m_pay.g2);
    end
  endtask

  // Inputs are set just after a negedge; one call advances one clock edge.
  task automatic cycle();
    #1;
    check("in_ready", in_ready, ref_in_ready());
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; instruction = 32'h13; imm_type = 3'd0; flush = 0;
    ex_load = 0; ex_rd = 0; wb_we = 0; wb_rd = 0; wb_result = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imm", imm, 32'h0);
    check("rst_gpr1", gpr1_value, 32'h0);
    check("rst_gpr2", gpr2_value, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_d64_out_valid", d64_out_valid, 1'b0);
    check("reset_opcode", opcode, 7'h0);
    check("reset_rd", rd, 5'h0);
    check("reset_imm", imm, 32'h0);
    check("reset_gpr1", gpr1_value, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x6,x5,-1 after writing x5
    wb_we = 1; wb_rd = 5; wb_result = 32'h1234;
    cycle();
    wb_we = 0; in_valid = 1; instruction = 32'hFFF2_8313; imm_type = 3'd0;
    cycle();
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_gpr1", gpr1_value, 32'h1234);
    check("t1_imm", imm, 32'hFFFF_FFFF);
    check("t1_rd", rd, 5'd6);

    // ADD x8,x7,x7 with x7 written in the capture cycle
    instruction = 32'h0073_8433; wb_we = 1; wb_rd = 7; wb_result = 32'hA5A5_A5A5;
    cycle();
    check("t2_gpr1_bypass", gpr1_value, 32'hA5A5_A5A5);
    check("t2_gpr2_bypass", gpr2_value, 32'hA5A5_A5A5);
    check("t2_nobypass_gpr1", d64_gpr1_value, 64'h0);
    check("t2_nobypass_gpr2", d64_gpr2_value, 64'h0);

    // SW x9,8(x2) held for three cycles, x9 written in the second
    wb_we = 0; instruction = 32'h0091_2423; imm_type = 3'd1;
    cycle();
    out_ready = 0; instruction = 32'h13; imm_type = 3'd0;
    for (int k = 0; k < 3; k++) begin
      wb_we = (k == 1); wb_rd = 9; wb_result = 32'h55;
      #1;
      check("t3_in_ready", in_ready, 1'b0);
      cycle();
      check("t3_imm", imm, 32'd8);
      check("t3_rs2", rs2, 5'd9);
      check("t3_gpr2", gpr2_value, (k >= 1) ? 32'h55 : 32'h0);
    end
    wb_we = 0;

    // Load-use stall on ADD x4,x3,x1
    out_ready = 1; ex_load = 1; ex_rd = 3; instruction = 32'h0011_8233;
    #1;
    check("t4_in_ready_stall", in_ready, 1'b0);
    cycle();
    check("t4_bubble", out_valid, 1'b0);
    ex_load = 0;
    #1;
    check("t4_in_ready_go", in_ready, 1'b1);
    cycle();
    check("t4_out_valid", out_valid, 1'b1);
    check("t4_rd", rd, 5'd4);

    // Flush while held, then x0 writes must not be visible
    out_ready = 0; instruction = 32'h13;
    cycle();
    flush = 1;
    #1;
    check("t5_in_ready_flush", in_ready, 1'b0);
    cycle();
    check("t5_flushed", out_valid, 1'b0);
    flush = 0; out_ready = 1; in_valid = 0; wb_we = 1; wb_rd = 0; wb_result = 32'hDEAD;
    cycle();
    in_valid = 1; instruction = 32'h0050_0093;
    cycle();
    check("t5_x0_read", gpr1_value, 32'h0);
    check("t5_imm", imm, 32'd5);
    wb_we = 0;

    // Immediate formats
    instruction = 32'hFE00_0EE3; imm_type = 3'd2;
    cycle();
    check("t6_b_imm", imm, 32'hFFFF_FFFC);
    check("t6_b_imm64", d64_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    instruction = 32'h0010_006F; imm_type = 3'd4;
    cycle();
    check("t6_j_imm", imm, 32'h800);
    instruction = 32'h8000_00B7; imm_type = 3'd3;
    cycle();
    check("t6_u_imm", imm, 32'h8000_0000);
    check("t6_u_imm64", d64_imm, 64'hFFFF_FFFF_8000_0000);
    check("t6_d64_valid", d64_out_valid, 1'b1);
    instruction = 32'hFFFF_FFFF; imm_type = 3'd6;
    cycle();
    check("t6_none_imm", imm, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = $urandom;
      imm_type    = 3'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
      ex_load     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       ex_rd = instruction[19:15];
        1:       ex_rd = instruction[24:20];
        default: ex_rd = 5'($urandom);
      endcase
      wb_we = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       wb_rd = instruction[19:15];
        1:       wb_rd = m_pay.rs2;
        default: wb_rd = 5'($urandom);
      endcase
      wb_result = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
